// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into little-endian word
// writes to instruction memory, holding the core in reset until the image is in.
`default_nettype none

module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] MAX_BYTES = 32'd16001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold,
  output logic [31:0] bytes_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]  r_state, w_next;
  logic [31:0] r_len;
  logic [1:0]  r_hdr_cnt;
  logic [31:0] r_bytes;
  logic [31:0] r_asm;
  logic [3:0]  r_be;
  logic [29:0] r_word_idx;
  logic        r_last;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_xfer, w_start, w_hdr_done, w_last, w_trig;
  logic [1:0]  w_lane;
  logic [31:0] w_len_full, w_asm_next;
  logic [3:0]  w_be_next;

  assign w_xfer     = s_valid & s_ready;
  assign w_start    = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_len_full = {s_data, r_len[23:0]};
  assign w_hdr_done = w_xfer & (r_state == S_LEN) & (r_hdr_cnt == 2'd3);
  assign w_lane     = r_bytes[1:0];
  assign w_last     = ((r_bytes + 32'd1) == r_len);
  assign w_trig     = w_xfer & (r_state == S_DATA) & ((w_lane == 2'd3) | w_last);

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{w_lane, 3'b000} +: 8] = s_data;
    w_be_next = r_be | (4'b0001 << w_lane);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN;
      S_LEN: begin
        if (w_hdr_done) begin
          if (w_len_full == 32'd0)           w_next = S_DONE;
          else if (w_len_full > MAX_BYTES)   w_next = S_ERR;
          else                               w_next = S_DATA;
        end
      end
      S_DATA:  if (w_trig) w_next = S_WRITE;
      S_WRITE: w_next = r_last ? S_DONE : S_DATA;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (r_state == S_LEN) | (r_state == S_DATA);
    mem_we   = (r_state == S_WRITE);
    mem_be   = mem_we ? r_mem_be : 4'h0;
    busy     = (r_state == S_LEN) | (r_state == S_DATA) | (r_state == S_WRITE);
    done     = (r_state == S_DONE);
    err      = (r_state == S_ERR);
    cpu_hold = (r_state != S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= 32'd0;
      r_hdr_cnt   <= 2'd0;
      r_bytes     <= 32'd0;
      r_asm       <= 32'd0;
      r_be        <= 4'd0;
      r_word_idx  <= 30'd0;
      r_last      <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
    end else begin
      if (w_start) begin
        r_len      <= 32'd0;
        r_hdr_cnt  <= 2'd0;
        r_bytes    <= 32'd0;
        r_asm      <= 32'd0;
        r_be       <= 4'd0;
        r_word_idx <= 30'd0;
        r_last     <= 1'b0;
      end
      if ((r_state == S_LEN) && w_xfer) begin
        r_len[{r_hdr_cnt, 3'b000} +: 8] <= s_data;
        r_hdr_cnt <= r_hdr_cnt + 2'd1;
      end
      if ((r_state == S_DATA) && w_xfer) begin
        r_bytes <= r_bytes + 32'd1;
        // The completed word is captured straight into the write registers,
        // so the assembly register is free again during the write bubble.
        if (w_trig) begin
          r_mem_addr  <= BASE_ADDR + {r_word_idx, 2'b00};
          r_mem_wdata <= w_asm_next;
          r_mem_be    <= w_be_next;
          r_asm       <= 32'd0;
          r_be        <= 4'd0;
          r_word_idx  <= r_word_idx + 30'd1;
          r_last      <= w_last;
        end else begin
          r_asm <= w_asm_next;
          r_be  <= w_be_next;
        end
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign bytes_loaded = r_bytes;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes are built
// from the driven payload and compared as mem_we pulses appear.
`default_nettype none

module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] MAXB = 32'd16001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, mem_we, busy, done, err, cpu_hold;
  logic [31:0] mem_addr, mem_wdata, bytes_loaded;
  logic [3:0]  mem_be;

  imem_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold),
    .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t q[$];
  int  n_err = 0;
  int  n_chk = 0;
  int  n_wr  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      n_wr++;
      check("wr_sready_low", {31'd0, s_ready}, 32'd0);
      check("wr_pending", {31'd0, (q.size() > 0)}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_wdata, e.d);
        check("wr_be", {28'd0, mem_be}, {28'd0, e.be});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    for (t = 0; t < 100 && !s_ready; t++) @(negedge clk);
    if (!s_ready) check("sready_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_image(input logic [31:0] len, input logic [7:0] pay[$],
                            input int maxgap, input int start_at);
    logic [31:0] word;
    logic [3:0]  be;
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], maxgap);
    if (len == 32'd0 || len > MAXB) return;
    word = 32'd0;
    be   = 4'd0;
    for (int i = 0; i < pay.size(); i++) begin
      if (i == start_at) pulse_start();
      send_byte(pay[i], maxgap);
      word[8*(i%4) +: 8] = pay[i];
      be[i%4] = 1'b1;
      if ((i % 4 == 3) || (i == int'(len) - 1)) begin
        q.push_back('{a: BASE + 32'(4 * (i / 4)), d: word, be: be});
        word = 32'd0;
        be   = 4'd0;
      end
    end
  endtask

  task automatic wait_end();
    int t;
    for (t = 0; t < 50 && !(done || err); t++) @(negedge clk);
    check("end_reached", {31'd0, (done | err)}, 32'd1);
  endtask

  task automatic check_done(input string tag, input logic [31:0] nbytes, input int nwrites, input int wr0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_sready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_bytes"}, bytes_loaded, nbytes);
    check({tag, "_nwr"}, 32'(n_wr - wr0), 32'(nwrites));
    check({tag, "_qempty"}, 32'(q.size()), 32'd0);
  endtask

  logic [7:0] p[$];
  int wr0;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sready", {31'd0, s_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_bytes", bytes_loaded, 32'd0);
    rst = 1'b1;

    // Full words
    wr0 = n_wr;
    pulse_start();
    check("len_busy", {31'd0, busy}, 32'd1);
    p = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_image(32'd8, p, 0, -1);
    wait_end();
    check_done("full", 32'd8, 2, wr0);

    // Partial tail
    wr0 = n_wr;
    pulse_start();
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_image(32'd5, p, 0, -1);
    wait_end();
    check_done("tail", 32'd5, 2, wr0);

    // Zero length: DONE right after the 4th header byte
    wr0 = n_wr;
    pulse_start();
    p = {};
    send_image(32'd0, p, 0, -1);
    @(negedge clk);
    check_done("zero", 32'd0, 0, wr0);

    // Oversize
    wr0 = n_wr;
    pulse_start();
    send_image(32'd16002, p, 0, -1);
    @(negedge clk);
    check("big_err", {31'd0, err}, 32'd1);
    check("big_hold", {31'd0, cpu_hold}, 32'd1);
    check("big_sready", {31'd0, s_ready}, 32'd0);
    check("big_done", {31'd0, done}, 32'd0);
    check("big_nwr", 32'(n_wr - wr0), 32'd0);
    wr0 = n_wr;
    pulse_start();
    check("big_err_clr", {31'd0, err}, 32'd0);
    p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_image(32'd4, p, 0, -1);
    wait_end();
    check_done("after_err", 32'd4, 1, wr0);

    // Random gaps, start mid-DATA ignored
    wr0 = n_wr;
    pulse_start();
    p = {};
    for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
    send_image(32'd12, p, 3, 6);
    wait_end();
    check_done("gaps", 32'd12, 3, wr0);

    // Async reset after 6 of 8 payload bytes, then a clean reload
    pulse_start();
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_image(32'd8, p, 0, -1);
    #2 rst = 1'b0;
    #1;
    check("arst_we", {31'd0, mem_we}, 32'd0);
    check("arst_hold", {31'd0, cpu_hold}, 32'd1);
    check("arst_bytes", bytes_loaded, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_qempty", 32'(q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wr0 = n_wr;
    pulse_start();
    p = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    send_image(32'd8, p, 1, -1);
    wait_end();
    check_done("reload", 32'd8, 2, wr0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
